// File: rtl/ballot_pkg.sv
// Shared definitions for the ballot front end and the downstream voting_machine.
// Holds the FSM state encoding, candidate codes and button-decode helpers.
package ballot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DEBOUNCE,
    CAST,
    RELEASE
  } state_t;

  typedef logic [2:0] cand_t;

  localparam cand_t CAND_NONE = 3'b000;
  localparam cand_t CAND_1    = 3'b001;
  localparam cand_t CAND_2    = 3'b010;
  localparam cand_t CAND_3    = 3'b011;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Button bit position -> candidate code; anything not one-hot maps to none.
  function automatic cand_t cand_code(input logic [2:0] oh);
    case (oh)
      3'b001:  return CAND_1;
      3'b010:  return CAND_2;
      3'b100:  return CAND_3;
      default: return CAND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ballot_if.sv
// Officer/button inputs and vote outputs of one ballot station.
interface ballot_if;
  import ballot_pkg::*;

  logic       arm;
  logic [2:0] btn;
  cand_t      candidate;
  logic       ready;
  logic       cast_done;
  logic       timeout;
  logic [7:0] ballots;

  modport master (
    output arm, btn,
    input  candidate, ready, cast_done, timeout, ballots
  );

  modport slave (
    input  arm, btn,
    output candidate, ready, cast_done, timeout, ballots
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for raw asynchronous button inputs.
module btn_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [1:0][W-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/ballot_unit.sv
// Ballot station: synchronizes and debounces three candidate buttons and
// emits exactly one registered candidate code per officer-opened ballot.
module ballot_unit
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic     clk,
  input  logic     rst,
  ballot_if.slave  bus
);

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  sbtn;
  logic [2:0]  latch;
  logic [7:0]  dcnt;
  logic [15:0] tcnt;
  cand_t       cand_q;
  logic        ready_q;
  logic        done_q;
  logic        tout_q;
  logic [7:0]  ballots_q;

  btn_sync #(.W(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (sbtn)
  );

  // The timeout counter keeps running through DEBOUNCE so a bouncing button
  // cannot hold a ballot open forever; a completed debounce wins over expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      latch     <= '0;
      dcnt      <= '0;
      tcnt      <= '0;
      cand_q    <= CAND_NONE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      ballots_q <= '0;
    end else begin
      cand_q <= CAND_NONE;
      done_q <= 1'b0;
      tout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state   <= ARMED;
            tcnt    <= '0;
            ready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (tcnt == TMO_LAST) begin
            state   <= IDLE;
            tout_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 16'd1;
            if (is_onehot(sbtn)) begin
              state <= DEBOUNCE;
              latch <= sbtn;
              dcnt  <= '0;
            end
          end
        end
        DEBOUNCE: begin
          if (sbtn == latch && dcnt == DEB_LAST) begin
            state   <= CAST;
            cand_q  <= cand_code(latch);
            done_q  <= 1'b1;
            ready_q <= 1'b0;
            if (ballots_q != 8'hFF) ballots_q <= ballots_q + 8'd1;
          end else if (tcnt == TMO_LAST) begin
            state   <= IDLE;
            tout_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 16'd1;
            if (sbtn != latch) begin
              state <= ARMED;
              dcnt  <= '0;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
        end
        CAST: begin
          state <= RELEASE;
          dcnt  <= '0;
        end
        RELEASE: begin
          // All buttons must be quiet for a full debounce window before re-arming.
          if (sbtn != 3'b000)        dcnt  <= '0;
          else if (dcnt == DEB_LAST) state <= IDLE;
          else                       dcnt  <= dcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.candidate = cand_q;
  assign bus.ready     = ready_q;
  assign bus.cast_done = done_q;
  assign bus.timeout   = tout_q;
  assign bus.ballots   = ballots_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Bench for ballot_unit: two instances (default timeout and a short one) share
// stimulus; a cycle model checks every output each cycle plus directed literals.
module tb_ballot_unit;

  localparam int DEB  = 4;
  localparam int TMO0 = 1000;
  localparam int TMO1 = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm;
  logic [2:0] btn;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  ballot_if b0 ();
  ballot_if b1 ();

  assign b0.arm = arm;
  assign b0.btn = btn;
  assign b1.arm = arm;
  assign b1.btn = btn;

  ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  // Behavioural model: open/releasing flags, stable-run length, ballot age.
  typedef struct {
    logic [2:0] s1, s2, prev, cand;
    bit         open, rel, done, tout;
    int         age, run, quiet, ballots;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.s1 = 3'b000; m.s2 = 3'b000; m.prev = 3'b000; m.cand = 3'b000;
    m.open = 0; m.rel = 0; m.done = 0; m.tout = 0;
    m.age = 0; m.run = 0; m.quiet = 0; m.ballots = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, logic a, logic [2:0] b, int tmo);
    mdl_t m;
    logic [2:0] s;
    bit oh;
    m = mi;
    s = m.s2;
    m.s2 = m.s1;
    m.s1 = b;
    oh = ($countones(s) == 1);
    m.cand = 3'b000; m.done = 0; m.tout = 0;
    if (m.rel) begin
      m.quiet = (s == 3'b000) ? m.quiet + 1 : 0;
      if (m.quiet == DEB) m.rel = 0;
    end else if (!m.open) begin
      if (a) begin m.open = 1; m.age = 0; m.run = 0; m.prev = 3'b000; end
    end else begin
      if (!oh)                            m.run = 0;
      else if (s == m.prev)               m.run = m.run + 1;
      else if ($countones(m.prev) == 1)   m.run = 0;
      else                                m.run = 1;
      m.prev = s;
      if (m.run == DEB + 1) begin
        m.cand = s[0] ? 3'd1 : (s[1] ? 3'd2 : 3'd3);
        m.done = 1;
        m.ballots = (m.ballots < 255) ? m.ballots + 1 : 255;
        m.open = 0; m.rel = 1; m.quiet = 0;
      end else if (m.age == tmo - 1) begin
        m.tout = 1; m.open = 0;
      end else begin
        m.age = m.age + 1;
      end
    end
    return m;
  endfunction

  mdl_t m0, m1;

  initial begin
    m0 = mreset();
    m1 = mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m0 = mreset();
        m1 = mreset();
      end else begin
        m0 = mstep(m0, arm, btn, TMO0);
        m1 = mstep(m1, arm, btn, TMO1);
      end
      if (clk) cyc = cyc + 1;
    end
  end

  task automatic cmp(input string nm, input logic [13:0] act, input mdl_t m);
    logic [13:0] exp;
    exp = {m.cand, m.open, m.done, m.tout, 8'(m.ballots)};
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc %0d: got cand=%b rdy=%b done=%b to=%b bal=%0d, want cand=%b rdy=%b done=%b to=%b bal=%0d",
               nm, cyc, act[13:11], act[10], act[9], act[8], act[7:0],
               exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  int casts0 = 0, casts1 = 0, castc0 = 0, lastc0 = 0, touts1 = 0, toc1 = 0;

  initial forever begin
    @(negedge clk);
    cmp("dut0", {b0.candidate, b0.ready, b0.cast_done, b0.timeout, b0.ballots}, m0);
    cmp("dut1", {b1.candidate, b1.ready, b1.cast_done, b1.timeout, b1.ballots}, m1);
    if (b0.cast_done === 1'b1) begin casts0++; castc0 = cyc; lastc0 = int'(b0.candidate); end
    if (b1.cast_done === 1'b1) casts1++;
    if (b1.timeout === 1'b1) begin touts1++; toc1 = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int c, c1, t1, p, a0;

  initial begin
    arm = 1'b0;
    btn = 3'b000;
    #2 rst = 1'b1;
    tick(2);
    chk("rst_cand0", int'(b0.candidate), 0);
    chk("rst_ready0", int'(b0.ready), 0);
    chk("rst_ballots0", int'(b0.ballots), 0);
    chk("rst_ready1", int'(b1.ready), 0);
    rst = 1'b0;
    tick(3);

    // reset while debouncing: no vote, count untouched
    arm = 1'b1; btn = 3'b010; tick(1); arm = 1'b0; tick(4);
    chk("deb_ready0", int'(b0.ready), 1);
    rst = 1'b1; #1;
    chk("midrst_cand0", int'(b0.candidate), 0);
    chk("midrst_ready0", int'(b0.ready), 0);
    chk("midrst_ballots0", int'(b0.ballots), 0);
    btn = 3'b000; tick(2); rst = 1'b0; tick(10);
    chk("midrst_casts0", casts0, 0);
    chk("midrst_idle0", int'(b0.ready), 0);

    // clean press of candidate 2
    c = casts0;
    arm = 1'b1; tick(1); arm = 1'b0; tick(2);
    btn = 3'b010; p = cyc; tick(20); btn = 3'b000; tick(12);
    chk("c2_count", casts0 - c, 1);
    chk("c2_latency", castc0 - p, 7);
    chk("c2_code", lastc0, 2);
    chk("c2_ballots", int'(b0.ballots), 1);
    chk("c2_idle", int'(b0.ready), 0);

    // bouncing candidate 1 then stable
    c = casts0;
    arm = 1'b1; tick(1); arm = 1'b0; tick(2);
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? 3'b001 : 3'b000;
      tick(2);
    end
    btn = 3'b001; p = cyc; tick(12); btn = 3'b000; tick(12);
    chk("bounce_count", casts0 - c, 1);
    chk("bounce_latency", castc0 - p, 7);
    chk("bounce_code", lastc0, 1);

    // two buttons held: no vote, then candidate 3
    c = casts0;
    arm = 1'b1; tick(1); arm = 1'b0; tick(2);
    btn = 3'b011; tick(50);
    chk("multi_ready", int'(b0.ready), 1);
    chk("multi_cand", int'(b0.candidate), 0);
    chk("multi_none", casts0 - c, 0);
    btn = 3'b100; p = cyc; tick(12); btn = 3'b000; tick(12);
    chk("c3_count", casts0 - c, 1);
    chk("c3_code", lastc0, 3);
    chk("c3_latency", castc0 - p, 7);

    // short-timeout instance expires; later press without arm is ignored there
    c1 = casts1; t1 = touts1; c = casts0;
    arm = 1'b1; a0 = cyc; tick(1); arm = 1'b0; tick(12);
    chk("to_count", touts1 - t1, 1);
    chk("to_time", toc1 - a0, 11);
    chk("to_ready1", int'(b1.ready), 0);
    chk("to_ready0", int'(b0.ready), 1);
    btn = 3'b001; tick(12); btn = 3'b000; tick(12);
    chk("to_novote1", casts1 - c1, 0);
    chk("to_vote0", casts0 - c, 1);

    // arm held high: one vote, re-open only after release completes
    c = casts0;
    arm = 1'b1; tick(2);
    btn = 3'b100; tick(10); btn = 3'b000;
    chk("hold_one", casts0 - c, 1);
    tick(10);
    chk("hold_reopen", int'(b0.ready), 1);
    chk("hold_still_one", casts0 - c, 1);
    arm = 1'b0; btn = 3'b001; tick(10); btn = 3'b000; tick(12);
    chk("hold_second", casts0 - c, 2);

    // saturation of the ballot counter
    c = casts0;
    for (int i = 0; i < 256; i++) begin
      arm = 1'b1; btn = 3'b001; tick(1); arm = 1'b0; tick(8);
      btn = 3'b000; tick(8);
    end
    chk("sat_casts", casts0 - c, 256);
    chk("sat_ballots0", int'(b0.ballots), 255);
    chk("sat_ballots1", int'(b1.ballots), 255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
